// File: rtl/scale_price_engine_if.sv
// ---------------------------------------------------------------------------
// scale_price_engine_if
//   Signal bundle between the scale front end (master) and the pricing core
//   (slave).
//   master drives : weightGrams, centimos, tareReq, start, addItem, clearTotal
//   slave drives  : precotara, precof, total, tareValue, busy, done, ovf, totOvf
// ---------------------------------------------------------------------------
interface scale_price_engine_if #(
  parameter int W_WIDTH   = 14,
  parameter int P_WIDTH   = 14,
  parameter int OUT_WIDTH = 20,
  parameter int TOT_WIDTH = 24
);
  logic [W_WIDTH-1:0]   weightGrams;
  logic [P_WIDTH-1:0]   centimos;
  logic                 tareReq;
  logic                 start;
  logic                 addItem;
  logic                 clearTotal;
  logic [W_WIDTH-1:0]   precotara;
  logic [OUT_WIDTH-1:0] precof;
  logic [TOT_WIDTH-1:0] total;
  logic [W_WIDTH-1:0]   tareValue;
  logic                 busy;
  logic                 done;
  logic                 ovf;
  logic                 totOvf;

  modport master (
    output weightGrams, centimos, tareReq, start, addItem, clearTotal,
    input  precotara, precof, total, tareValue, busy, done, ovf, totOvf
  );

  modport slave (
    input  weightGrams, centimos, tareReq, start, addItem, clearTotal,
    output precotara, precof, total, tareValue, busy, done, ovf, totOvf
  );
endinterface

// File: rtl/scale_price_engine.sv
// ---------------------------------------------------------------------------
// scale_price_engine
//   Pricing core of the weighing scale. Holds a tare, latches the net weight
//   on start, multiplies it by the per-kg price (shift-add, one net bit per
//   cycle), divides by 1000 (restoring, one quotient bit per cycle), rounds
//   half-up and saturates to the item price. A saturating running total
//   accumulates item prices on request.
// Ports
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : slave side of scale_price_engine_if
//           in : weightGrams, centimos, tareReq, start, addItem, clearTotal
//           out: precotara, precof, total, tareValue, busy, done, ovf, totOvf
// ---------------------------------------------------------------------------
module scale_price_engine #(
  parameter int W_WIDTH   = 14,
  parameter int P_WIDTH   = 14,
  parameter int OUT_WIDTH = 20,
  parameter int TOT_WIDTH = 24
) (
  input  logic                 clk,
  input  logic                 rst_n,
  scale_price_engine_if.slave  bus
);

  localparam int PW      = W_WIDTH + P_WIDTH;
  localparam int CW      = $clog2(PW + 1);
  localparam int RW      = 11;  // remainder < 1000, shifted value < 2000
  localparam int DIVISOR = 1000;
  localparam int HALF    = 500;
  localparam int XW      = ((PW + 1) > OUT_WIDTH) ? (PW + 1) : OUT_WIDTH;
  localparam int SUM_W   = ((TOT_WIDTH > OUT_WIDTH) ? TOT_WIDTH : OUT_WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t               state;
  logic [CW-1:0]        cnt;
  logic [W_WIDTH-1:0]   tare_q;
  logic [W_WIDTH-1:0]   net_q;
  logic [W_WIDTH-1:0]   mplier;
  logic [PW-1:0]        mcand;
  logic [PW-1:0]        acc;     // product during MUL, quotient after DIV
  logic [RW-1:0]        rem;
  logic [OUT_WIDTH-1:0] precof_q;
  logic [TOT_WIDTH-1:0] total_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 ovf_q;
  logic                 tot_ovf_q;

  logic [RW-1:0]        rem_sh;
  logic [PW:0]          rounded;
  logic [OUT_WIDTH:0]   sat_res;
  logic [TOT_WIDTH:0]   add_res;

  function automatic logic [W_WIDTH-1:0] sat0_sub(input logic [W_WIDTH-1:0] a,
                                                  input logic [W_WIDTH-1:0] b);
    return (a >= b) ? (a - b) : '0;
  endfunction

  function automatic logic [PW:0] round_half_up(input logic [PW-1:0] q,
                                                input logic [RW-1:0] r);
    return {1'b0, q} + {{PW{1'b0}}, (r >= RW'(HALF))};
  endfunction

  // {saturated, value}
  function automatic logic [OUT_WIDTH:0] sat_out(input logic [PW:0] x);
    logic [XW-1:0] xe;
    logic [XW-1:0] maxe;
    xe   = XW'(x);
    maxe = XW'({OUT_WIDTH{1'b1}});
    if (xe > maxe) return {1'b1, {OUT_WIDTH{1'b1}}};
    return {1'b0, OUT_WIDTH'(xe)};
  endfunction

  // {clamped, value}
  function automatic logic [TOT_WIDTH:0] sat_total(input logic [TOT_WIDTH-1:0] t,
                                                   input logic [OUT_WIDTH-1:0] p);
    logic [SUM_W-1:0] s;
    s = SUM_W'(t) + SUM_W'(p);
    if (s > SUM_W'({TOT_WIDTH{1'b1}})) return {1'b1, {TOT_WIDTH{1'b1}}};
    return {1'b0, TOT_WIDTH'(s)};
  endfunction

  // Restoring division: bring the next dividend bit into the remainder.
  assign rem_sh  = {rem[RW-2:0], acc[PW-1]};
  assign rounded = round_half_up(acc, rem);
  assign sat_res = sat_out(rounded);
  assign add_res = sat_total(total_q, precof_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      tare_q    <= '0;
      net_q     <= '0;
      mplier    <= '0;
      mcand     <= '0;
      acc       <= '0;
      rem       <= '0;
      precof_q  <= '0;
      total_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ovf_q     <= 1'b0;
      tot_ovf_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        // IDLE: accept exactly one request, highest priority first
        IDLE: begin
          if (bus.clearTotal) begin
            total_q   <= '0;
            tot_ovf_q <= 1'b0;
          end else if (bus.tareReq) begin
            tare_q <= bus.weightGrams;
          end else if (bus.start) begin
            net_q  <= sat0_sub(bus.weightGrams, tare_q);
            mplier <= sat0_sub(bus.weightGrams, tare_q);
            mcand  <= PW'(bus.centimos);
            acc    <= '0;
            cnt    <= '0;
            busy_q <= 1'b1;
            state  <= MUL;
          end else if (bus.addItem) begin
            total_q   <= add_res[TOT_WIDTH-1:0];
            tot_ovf_q <= tot_ovf_q | add_res[TOT_WIDTH];
          end
        end
        // MUL: one multiplier bit per cycle, W_WIDTH cycles
        MUL: begin
          if (mplier[0]) acc <= acc + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          if (cnt == CW'(W_WIDTH - 1)) begin
            cnt   <= '0;
            rem   <= '0;
            state <= DIV;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        // DIV: one quotient bit per cycle, shifted into acc from the bottom
        DIV: begin
          if (rem_sh >= RW'(DIVISOR)) begin
            rem <= rem_sh - RW'(DIVISOR);
            acc <= {acc[PW-2:0], 1'b1};
          end else begin
            rem <= rem_sh;
            acc <= {acc[PW-2:0], 1'b0};
          end
          if (cnt == CW'(PW - 1)) begin
            cnt   <= '0;
            state <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        // DONE: round, saturate, publish
        DONE: begin
          precof_q <= sat_res[OUT_WIDTH-1:0];
          ovf_q    <= sat_res[OUT_WIDTH];
          done_q   <= 1'b1;
          busy_q   <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.precotara = net_q;
  assign bus.precof    = precof_q;
  assign bus.total     = total_q;
  assign bus.tareValue = tare_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.ovf       = ovf_q;
  assign bus.totOvf    = tot_ovf_q;

endmodule

// File: tb/tb_scale_price_engine.sv
// ---------------------------------------------------------------------------
// tb_scale_price_engine
//   Self-checking bench for scale_price_engine. A behavioural model computes
//   the expected outputs from plain arithmetic; a compare process checks all
//   outputs every cycle, and directed scenarios pin literal values.
// ---------------------------------------------------------------------------
module tb_scale_price_engine;

  localparam int W  = 14;
  localparam int P  = 14;
  localparam int OW = 18;
  localparam int TW = 10;
  localparam int L  = 2 * W + P + 1;
  localparam longint OMAX = (64'd1 << OW) - 1;
  localparam longint TMAX = (64'd1 << TW) - 1;
  localparam longint WMAX = (64'd1 << W) - 1;
  localparam longint PMAX = (64'd1 << P) - 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int n_tests  = 0;
  int n_fail   = 0;
  int done_cnt = 0;

  scale_price_engine_if #(.W_WIDTH(W), .P_WIDTH(P), .OUT_WIDTH(OW), .TOT_WIDTH(TW)) bus();

  scale_price_engine #(.W_WIDTH(W), .P_WIDTH(P), .OUT_WIDTH(OW), .TOT_WIDTH(TW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model
  longint m_tare = 0, m_net = 0, m_precof = 0, m_total = 0, pend_precof = 0;
  bit     m_ovf = 0, m_totovf = 0, m_busy = 0, m_done = 0, pend_ovf = 0;
  int     m_left = 0;

  initial begin
    longint w, prod, q;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        m_tare = 0; m_net = 0; m_precof = 0; m_total = 0;
        m_ovf = 0; m_totovf = 0; m_busy = 0; m_done = 0; m_left = 0;
      end else begin
        m_done = 0;
        if (m_busy) begin
          m_left--;
          if (m_left == 0) begin
            m_busy = 0; m_done = 1; m_precof = pend_precof; m_ovf = pend_ovf;
          end
        end else if (bus.clearTotal) begin
          m_total = 0; m_totovf = 0;
        end else if (bus.tareReq) begin
          m_tare = longint'(bus.weightGrams);
        end else if (bus.start) begin
          w     = longint'(bus.weightGrams);
          m_net = (w >= m_tare) ? w - m_tare : 0;
          prod  = m_net * longint'(bus.centimos);
          q     = (prod + 500) / 1000;
          if (q > OMAX) begin pend_precof = OMAX; pend_ovf = 1; end
          else begin pend_precof = q; pend_ovf = 0; end
          m_busy = 1; m_left = L;
        end else if (bus.addItem) begin
          q = m_total + m_precof;
          if (q > TMAX) begin m_total = TMAX; m_totovf = 1; end
          else m_total = q;
        end
      end
    end
  end

  // Per-cycle compare and done counter
  initial forever begin
    @(negedge clk);
    check("precotara", longint'(bus.precotara), m_net);
    check("precof",    longint'(bus.precof),    m_precof);
    check("total",     longint'(bus.total),     m_total);
    check("tareValue", longint'(bus.tareValue), m_tare);
    check("busy",      longint'(bus.busy),      longint'(m_busy));
    check("done",      longint'(bus.done),      longint'(m_done));
    check("ovf",       longint'(bus.ovf),       longint'(m_ovf));
    check("totOvf",    longint'(bus.totOvf),    longint'(m_totovf));
    if (bus.done) done_cnt++;
  end

  task automatic do_tare(input longint w);
    @(negedge clk); bus.weightGrams = W'(w); bus.tareReq = 1'b1;
    @(negedge clk); bus.tareReq = 1'b0;
  endtask

  task automatic do_add();
    @(negedge clk); bus.addItem = 1'b1;
    @(negedge clk); bus.addItem = 1'b0;
  endtask

  task automatic do_clear();
    @(negedge clk); bus.clearTotal = 1'b1;
    @(negedge clk); bus.clearTotal = 1'b0;
  endtask

  task automatic wait_done(input bit scramble, inout int lat);
    while (!bus.done && lat < 200) begin
      if (scramble) begin
        bus.weightGrams = W'($urandom);
        bus.centimos    = P'($urandom);
      end
      @(negedge clk);
      lat++;
    end
    if (!bus.done) check("done_timeout", 0, 1);
  endtask

  task automatic do_price(input longint w, input longint c, input bit scramble, output int lat);
    @(negedge clk); bus.weightGrams = W'(w); bus.centimos = P'(c); bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    check("busy_after_start", longint'(bus.busy), 1);
    lat = 0;
    wait_done(scramble, lat);
  endtask

  function automatic longint pick(input longint maxv);
    int r;
    r = int'($urandom_range(0, 9));
    if (r == 0) return 0;
    if (r == 1) return maxv;
    return longint'($urandom_range(0, 32'(maxv)));
  endfunction

  initial begin
    int lat, dc;
    bus.weightGrams = '0; bus.centimos = '0;
    bus.tareReq = 1'b0; bus.start = 1'b0; bus.addItem = 1'b0; bus.clearTotal = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_total", longint'(bus.total), 0);
    check("reset_precof", longint'(bus.precof), 0);
    rst_n = 1'b1;

    // Price path
    do_tare(200);
    check("tare_200", longint'(bus.tareValue), 200);
    do_price(1450, 399, 1'b1, lat);
    check("latency", lat, L);
    check("lit_precotara", longint'(bus.precotara), 1250);
    check("lit_precof_499", longint'(bus.precof), 499);
    check("lit_ovf_0", longint'(bus.ovf), 0);
    @(negedge clk);
    check("done_one_cycle", longint'(bus.done), 0);

    // Accumulation and saturation
    do_add(); check("total_1", longint'(bus.total), 499);
    do_add(); check("total_2", longint'(bus.total), 998);
    check("totovf_2", longint'(bus.totOvf), 0);
    do_add(); check("total_3", longint'(bus.total), 1023);
    check("totovf_3", longint'(bus.totOvf), 1);
    do_clear();
    check("clear_total", longint'(bus.total), 0);
    check("clear_totovf", longint'(bus.totOvf), 0);

    // Round half up
    do_tare(0);
    do_price(500, 1, 1'b0, lat); check("round_500", longint'(bus.precof), 1);
    do_price(499, 1, 1'b0, lat); check("round_499", longint'(bus.precof), 0);

    // Below tare
    do_tare(300);
    do_price(100, 999, 1'b0, lat);
    check("below_net", longint'(bus.precotara), 0);
    check("below_precof", longint'(bus.precof), 0);

    // Item price saturation
    do_tare(0);
    do_price(WMAX, PMAX, 1'b0, lat);
    check("sat_precof", longint'(bus.precof), OMAX);
    check("sat_ovf", longint'(bus.ovf), 1);
    do_price(1000, 1000, 1'b0, lat);
    check("unsat_precof", longint'(bus.precof), 1000);
    check("unsat_ovf", longint'(bus.ovf), 0);
    do_add();
    check("total_1000", longint'(bus.total), 1000);

    // Busy protection
    dc = done_cnt;
    @(negedge clk); bus.weightGrams = W'(1000); bus.centimos = P'(3); bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    repeat (5) @(negedge clk);
    bus.weightGrams = W'(5); bus.centimos = P'(5); bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0; bus.weightGrams = W'(77); bus.tareReq = 1'b1;
    @(negedge clk); bus.tareReq = 1'b0; bus.addItem = 1'b1;
    @(negedge clk); bus.addItem = 1'b0;
    lat = 0;
    wait_done(1'b0, lat);
    check("busy_tare", longint'(bus.tareValue), 0);
    check("busy_total", longint'(bus.total), 1000);
    check("busy_precof", longint'(bus.precof), 3);
    repeat (60) @(negedge clk);
    check("busy_one_done", done_cnt - dc, 1);

    // Reset mid-operation
    @(negedge clk); bus.weightGrams = W'(2000); bus.centimos = P'(2000); bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    repeat (19) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_precotara", longint'(bus.precotara), 0);
    check("rst_precof", longint'(bus.precof), 0);
    check("rst_total", longint'(bus.total), 0);
    check("rst_tare", longint'(bus.tareValue), 0);
    check("rst_busy", longint'(bus.busy), 0);
    check("rst_done", longint'(bus.done), 0);
    check("rst_ovf", longint'(bus.ovf), 0);
    check("rst_totovf", longint'(bus.totOvf), 0);
    dc = done_cnt;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (60) @(negedge clk);
    check("rst_no_done", done_cnt - dc, 0);
    do_price(1450, 399, 1'b0, lat);
    check("rst_latency", lat, L);
    check("rst_fresh_precof", longint'(bus.precof), 579);

    // Random traffic, checked every cycle by the model
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      bus.weightGrams = W'(pick(WMAX));
      bus.centimos    = P'(pick(PMAX));
      bus.start       = ($urandom_range(0, 7) == 0);
      bus.tareReq     = ($urandom_range(0, 19) == 0);
      bus.addItem     = ($urandom_range(0, 4) == 0);
      bus.clearTotal  = ($urandom_range(0, 39) == 0);
    end
    @(negedge clk);
    bus.start = 1'b0; bus.tareReq = 1'b0; bus.addItem = 1'b0; bus.clearTotal = 1'b0;
    repeat (60) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
